// File: rtl/program_launcher_pkg.sv
// Shared definitions for the program launcher.
// Holds the FSM state encoding, the program ID constants handed to the
// register file through program_selector, the parameter defaults, and a
// small helper for sizing counters.
package program_launcher_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HOLD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

  // Program IDs as seen on program_selector (request bit i -> ID i+1)
  localparam int PROG_NONE  = 0;
  localparam int PROG_FIB   = 1;
  localparam int PROG_SORT  = 2;
  localparam int PROG_SAVE  = 3;
  localparam int PROG_LOAD  = 4;
  localparam int PROG_PUSHA = 5;

  // Parameter defaults
  localparam int DEF_NUM_PROGS      = 5;
  localparam int DEF_HOLD_CYCLES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/program_launcher_if.sv
// Handshake bundle between the program launcher and its surroundings.
// Ports:
//   req              requester -> launcher, level requests, one bit per program
//   proc_done        processor -> launcher, completion of the launched program
//   program_selector launcher -> processor, 0 = none, else program ID
//   launch           launcher -> processor, one-cycle pulse at launch start
//   busy             launcher status, high whenever not idle
//   pending          launcher status, queued requests not yet served
//   timeout          launcher status, one-cycle pulse on RUN abort
// Modports: master = requester/processor side, slave = the launcher itself.
interface program_launcher_if #(
  parameter int NUM_PROGS = 5
);

  logic [NUM_PROGS-1:0] req;
  logic                 proc_done;
  logic [31:0]          program_selector;
  logic                 launch;
  logic                 busy;
  logic [NUM_PROGS-1:0] pending;
  logic                 timeout;

  modport master (
    output req, proc_done,
    input  program_selector, launch, busy, pending, timeout
  );

  modport slave (
    input  req, proc_done,
    output program_selector, launch, busy, pending, timeout
  );

endinterface

// File: rtl/program_launcher_prio_pick.sv
// Combinational lowest-index-first picker.
// Ports:
//   vec   input  NUM_PROGS  candidate bits
//   idx   output IDX_W      index of the lowest set bit (0 when none set)
//   valid output 1          high when any bit of vec is set
module prio_pick #(
  parameter int NUM_PROGS = 5,
  parameter int IDX_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic [NUM_PROGS-1:0] vec,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  // Scan from the top down so the last hit, the lowest index, wins
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_PROGS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/program_launcher.sv
// Program launcher: turns level requests into queued, one-at-a-time program
// launches. A launch drives program_selector with the program ID for
// HOLD_CYCLES cycles (the processor copy window), then waits in RUN for
// proc_done or aborts after TIMEOUT_CYCLES cycles.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      program_launcher_if.slave (req, proc_done in; selector,
//            launch, busy, pending, timeout out)
module program_launcher
  import program_launcher_pkg::*;
#(
  parameter int NUM_PROGS      = DEF_NUM_PROGS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               reset_n,
  program_launcher_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam int IDX_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  state_t               state_q, state_d;
  logic [NUM_PROGS-1:0] req_q;
  logic [NUM_PROGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          sel_q, sel_d;
  logic                 launch_q, launch_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_PROGS-1:0] rise;
  logic [NUM_PROGS-1:0] clear;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  prio_pick #(
    .NUM_PROGS (NUM_PROGS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .vec   (pending_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    rise      = bus.req & ~req_q;
    clear     = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    launch_d  = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (pick_valid) begin
          clear    = NUM_PROGS'(1) << pick_idx;
          sel_d    = 32'(pick_idx) + 32'd1;
          launch_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // proc_done is deliberately not looked at here
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          sel_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        sel_d = '0;
        // Completion is checked first so it beats a coinciding expiry
        if (bus.proc_done) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        sel_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // A fresh edge on the bit being served keeps it pending
    pending_d = (pending_q & ~clear) | rise;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      launch_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= bus.req;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      launch_q  <= launch_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.program_selector = sel_q;
  assign bus.launch           = launch_q;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.pending          = pending_q;
  assign bus.timeout          = timeout_q;

endmodule

// File: tb/tb_program_launcher.sv
// Scoreboard bench for program_launcher (HOLD_CYCLES=2, TIMEOUT_CYCLES=16).
// The stimulus thread pushes expected launch/timeout events into a queue;
// a monitor on the falling edge pops and compares whenever the DUT pulses
// launch or timeout, and also measures how long program_selector is held.
module tb_program_launcher;

  localparam int NP         = 5;
  localparam int HOLD       = 2;
  localparam int TMO        = 16;
  localparam int EV_TIMEOUT = 100;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   hold_count;
  int   expq[$];

  program_launcher_if #(.NUM_PROGS(NP)) bus();

  program_launcher #(
    .NUM_PROGS      (NP),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NP-1:0] r, input logic d);
    bus.req       = r;
    bus.proc_done = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: event scoreboard plus selector hold-length measurement
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_count = 0;
    end else begin
      if (bus.launch || bus.timeout) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected event: sel=%0d timeout=%0b, expected none",
                   bus.program_selector, bus.timeout);
        end else begin
          checkOutput("event", bus.timeout ? 32'(EV_TIMEOUT) : bus.program_selector,
                      32'(expq.pop_front()));
        end
      end
      if (bus.program_selector != 0) begin
        hold_count++;
      end else if (hold_count != 0) begin
        checkOutput("hold length", 32'(hold_count), 32'(HOLD));
        hold_count = 0;
      end
    end
  end

  // Global watchdog
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clock       = 1'b0;
    reset_n     = 1'b0;
    vectors     = 0;
    miscompares = 0;
    hold_count  = 0;
    applyStimulus('0, 1'b0);
    #2;
    checkOutput("reset sel", bus.program_selector, 0);
    checkOutput("reset launch", 32'(bus.launch), 0);
    checkOutput("reset busy", 32'(bus.busy), 0);
    checkOutput("reset pending", 32'(bus.pending), 0);
    checkOutput("reset timeout", 32'(bus.timeout), 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Single FIB launch
    expq.push_back(1);
    applyStimulus(5'b00001, 1'b0);
    tick(1);
    checkOutput("t1 pending", 32'(bus.pending), 32'h01);
    checkOutput("t1 busy idle", 32'(bus.busy), 0);
    tick(1);
    checkOutput("t1 busy", 32'(bus.busy), 1);
    checkOutput("t1 sel", bus.program_selector, 1);
    checkOutput("t1 launch", 32'(bus.launch), 1);
    tick(1);
    checkOutput("t1 sel hold2", bus.program_selector, 1);
    checkOutput("t1 launch low", 32'(bus.launch), 0);
    tick(1);
    checkOutput("t1 sel run", bus.program_selector, 0);
    checkOutput("t1 busy run", 32'(bus.busy), 1);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    checkOutput("t1 busy done", 32'(bus.busy), 0);
    applyStimulus(5'b00000, 1'b0);

    // SORT and PUSHA together: SORT first
    expq.push_back(2);
    expq.push_back(5);
    applyStimulus(5'b10010, 1'b0);
    tick(2);
    checkOutput("t2 sel sort", bus.program_selector, 2);
    checkOutput("t2 pending", 32'(bus.pending), 32'h10);
    tick(2);
    checkOutput("t2 pending run", 32'(bus.pending), 32'h10);
    checkOutput("t2 busy run", 32'(bus.busy), 1);
    applyStimulus(5'b10010, 1'b1);
    tick(1);
    applyStimulus(5'b10010, 1'b0);
    tick(1);
    checkOutput("t2 sel pusha", bus.program_selector, 5);
    tick(2);
    applyStimulus(5'b10010, 1'b1);
    tick(1);
    checkOutput("t2 idle", 32'(bus.busy), 0);
    checkOutput("t2 pending empty", 32'(bus.pending), 0);
    applyStimulus(5'b00000, 1'b0);

    // LOAD raised twice during RUN -> one launch
    expq.push_back(1);
    expq.push_back(4);
    applyStimulus(5'b00001, 1'b0);
    tick(4);
    applyStimulus(5'b01000, 1'b0); tick(1);
    applyStimulus(5'b00000, 1'b0); tick(1);
    applyStimulus(5'b01000, 1'b0); tick(1);
    applyStimulus(5'b00000, 1'b0); tick(1);
    checkOutput("t3 pending", 32'(bus.pending), 32'h08);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    applyStimulus(5'b00000, 1'b0);
    tick(1);
    checkOutput("t3 sel load", bus.program_selector, 4);
    checkOutput("t3 pending cleared", 32'(bus.pending), 0);
    tick(2);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    applyStimulus(5'b00000, 1'b0);
    tick(4);
    checkOutput("t3 no relaunch", 32'(bus.busy), 0);

    // Timeout after 16 RUN cycles, then SAVE served
    expq.push_back(1);
    expq.push_back(EV_TIMEOUT);
    expq.push_back(3);
    applyStimulus(5'b00001, 1'b0);
    tick(2);
    applyStimulus(5'b00101, 1'b0);
    tick(2);
    tick(15);
    checkOutput("t4 no timeout yet", 32'(bus.timeout), 0);
    checkOutput("t4 busy before", 32'(bus.busy), 1);
    tick(1);
    checkOutput("t4 timeout", 32'(bus.timeout), 1);
    checkOutput("t4 idle", 32'(bus.busy), 0);
    tick(1);
    checkOutput("t4 timeout pulse", 32'(bus.timeout), 0);
    checkOutput("t4 sel save", bus.program_selector, 3);
    applyStimulus(5'b00000, 1'b0);
    tick(2);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    applyStimulus(5'b00000, 1'b0);

    // proc_done coinciding with expiry wins
    expq.push_back(2);
    applyStimulus(5'b00010, 1'b0);
    tick(4);
    applyStimulus(5'b00000, 1'b0);
    tick(15);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    checkOutput("t5 no timeout", 32'(bus.timeout), 0);
    checkOutput("t5 idle", 32'(bus.busy), 0);
    applyStimulus(5'b00000, 1'b0);
    tick(1);

    // proc_done during HOLD is ignored
    expq.push_back(5);
    applyStimulus(5'b10000, 1'b0);
    tick(2);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    checkOutput("t6 sel hold", bus.program_selector, 5);
    applyStimulus(5'b00000, 1'b0);
    tick(1);
    checkOutput("t6 run sel", bus.program_selector, 0);
    checkOutput("t6 run busy", 32'(bus.busy), 1);
    tick(1);
    checkOutput("t6 still run", 32'(bus.busy), 1);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    checkOutput("t6 done", 32'(bus.busy), 0);
    applyStimulus(5'b00000, 1'b0);

    // New edge on the bit being cleared keeps it pending
    expq.push_back(1);
    expq.push_back(2);
    expq.push_back(2);
    applyStimulus(5'b00001, 1'b0);
    tick(4);
    applyStimulus(5'b00010, 1'b0); tick(1);
    applyStimulus(5'b00000, 1'b0); tick(1);
    checkOutput("t7 pending", 32'(bus.pending), 32'h02);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    applyStimulus(5'b00010, 1'b0);
    tick(1);
    checkOutput("t7 sel sort", bus.program_selector, 2);
    checkOutput("t7 set wins", 32'(bus.pending), 32'h02);
    applyStimulus(5'b00000, 1'b0);
    tick(2);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    applyStimulus(5'b00000, 1'b0);
    tick(1);
    checkOutput("t7 sel sort again", bus.program_selector, 2);
    checkOutput("t7 pending empty", 32'(bus.pending), 0);
    tick(2);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    applyStimulus(5'b00000, 1'b0);

    // Reset in the second HOLD cycle with SAVE pending
    expq.push_back(1);
    applyStimulus(5'b00101, 1'b0);
    tick(3);
    checkOutput("t8 pending", 32'(bus.pending), 32'h04);
    checkOutput("t8 sel", bus.program_selector, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t8 rst sel", bus.program_selector, 0);
    checkOutput("t8 rst launch", 32'(bus.launch), 0);
    checkOutput("t8 rst busy", 32'(bus.busy), 0);
    checkOutput("t8 rst pending", 32'(bus.pending), 0);
    checkOutput("t8 rst timeout", 32'(bus.timeout), 0);
    applyStimulus(5'b00000, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    checkOutput("t8 quiet busy", 32'(bus.busy), 0);
    checkOutput("t8 quiet pending", 32'(bus.pending), 0);
    expq.push_back(4);
    applyStimulus(5'b01000, 1'b0);
    tick(2);
    checkOutput("t8 sel load", bus.program_selector, 4);
    tick(2);
    applyStimulus(5'b00000, 1'b1);
    tick(1);
    applyStimulus(5'b00000, 1'b0);
    tick(3);

    checkOutput("events outstanding", 32'(expq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
